// File: rtl/fetch_unit_if.sv
// Controller-side bus of the fetch unit: strobes in, PC/IR/status out.
// FETCH_BREAKPOINT_EN adds the breakpoint compare signals.
interface fetch_unit_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int OPC_W  = 3,
    parameter int CNT_W  = 16
);
    logic [DATA_W-1:0] mem_data;
    logic              fetch;
    logic              load_ir;
    logic              inc_pc;
    logic              load_pc;
    logic              halt;
    logic              resume;
    logic [ADDR_W-1:0] addr;
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              pc_wrap;
    logic [CNT_W-1:0]  retired;
`ifdef FETCH_BREAKPOINT_EN
    logic              bp_valid;
    logic [ADDR_W-1:0] bp_addr;
    logic              bp_hit;
`endif

    modport master (
        output mem_data, fetch, load_ir, inc_pc, load_pc, halt, resume,
        input  addr, opcode, ir_addr, pc, halted, pc_wrap, retired
`ifdef FETCH_BREAKPOINT_EN
        , output bp_valid, bp_addr
        , input  bp_hit
`endif
    );

    modport slave (
        input  mem_data, fetch, load_ir, inc_pc, load_pc, halt, resume,
        output addr, opcode, ir_addr, pc, halted, pc_wrap, retired
`ifdef FETCH_BREAKPOINT_EN
        , input  bp_valid, bp_addr
        , output bp_hit
`endif
    );
endinterface

// File: rtl/fetch_unit.sv
// PC / IR stage of a VeriRISC-style CPU with sticky halt latch and retired counter.
// Optional breakpoint compare on instruction load: define FETCH_BREAKPOINT_EN.
module fetch_unit #(
    parameter int                ADDR_W   = 5,
    parameter int                DATA_W   = 8,
    parameter int                OPC_W    = 3,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input logic          clk,
    input logic          rst_,
    fetch_unit_if.slave  bus
);
    typedef enum logic { RUN = 1'b0, HALTED = 1'b1 } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] ir;
    logic [CNT_W-1:0]  retired_q;
    logic              wrap_q;
    logic              run;
    logic              ir_accept;
    logic              bp_trig;

    assign run       = (state == RUN);
    assign ir_accept = bus.load_ir && run;

`ifdef FETCH_BREAKPOINT_EN
    logic bp_hit_q;
    assign bp_trig = ir_accept && bus.bp_valid && (pc_q == bus.bp_addr);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) bp_hit_q <= 1'b0;
        else       bp_hit_q <= bp_trig;
    end

    assign bus.bp_hit = bp_hit_q;
`else
    assign bp_trig = 1'b0;
`endif

    // Halt latch: halt (or breakpoint) dominates resume.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (bus.halt || bp_trig)     state <= HALTED;
                HALTED:  if (bus.resume && !bus.halt) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    // load_pc reads the pre-edge IR operand, so a same-cycle load_ir does not affect the jump.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pc_q   <= RESET_PC;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (run) begin
                if (bus.load_pc) begin
                    pc_q <= ir[ADDR_W-1:0];
                end else if (bus.inc_pc) begin
                    pc_q   <= pc_q + ADDR_W'(1);
                    wrap_q <= &pc_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ir        <= '0;
            retired_q <= '0;
        end else if (ir_accept) begin
            ir <= bus.mem_data;
            if (retired_q != {CNT_W{1'b1}}) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign bus.addr    = bus.fetch ? pc_q : ir[ADDR_W-1:0];
    assign bus.opcode  = ir[DATA_W-1 -: OPC_W];
    assign bus.ir_addr = ir[ADDR_W-1:0];
    assign bus.pc      = pc_q;
    assign bus.halted  = (state == HALTED);
    assign bus.pc_wrap = wrap_q;
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized strobes
// against an arithmetic reference model.
module tb_fetch_unit;
    logic clk;
    logic rst_;
    int   n_cmp;
    int   n_fail;

    fetch_unit_if #(.ADDR_W(5), .DATA_W(8), .OPC_W(3), .CNT_W(16)) bus ();

    fetch_unit #(.ADDR_W(5), .DATA_W(8), .OPC_W(3), .RESET_PC(5'd0), .CNT_W(16)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, plain integers.
    int m_pc, m_ir, m_ret;
    bit m_halted, m_wrap, m_bp;

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_ret = 0;
        m_halted = 0; m_wrap = 0; m_bp = 0;
    endtask

    // Advance model from current inputs, clock once, sample at +1, drop pulses.
    task automatic tick();
        int npc = m_pc;
        int nir = m_ir;
        int nret = m_ret;
        bit nh = m_halted;
        bit nw = 0;
        bit nbp = 0;
        bit acc;
        acc = bus.load_ir && !m_halted;
        if (!m_halted) begin
            if (bus.load_pc) npc = m_ir % 32;
            else if (bus.inc_pc) begin
                npc = (m_pc + 1) % 32;
                nw  = (m_pc == 31);
            end
        end
        if (acc) begin
            nir = int'(bus.mem_data);
            if (m_ret < 65535) nret = m_ret + 1;
        end
`ifdef FETCH_BREAKPOINT_EN
        nbp = acc && bus.bp_valid && (int'(bus.bp_addr) == m_pc);
`endif
        if (bus.halt || nbp) nh = 1;
        else if (bus.resume) nh = 0;
        @(posedge clk);
        #1;
        m_pc = npc; m_ir = nir; m_ret = nret;
        m_halted = nh; m_wrap = nw; m_bp = nbp;
        bus.load_ir = 0; bus.inc_pc = 0; bus.load_pc = 0;
        bus.halt = 0; bus.resume = 0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (bus.pc !== 5'd0)      begin n_fail++; $display("FAIL reset_pc: got %h want 00", bus.pc); end
        n_cmp++; if (bus.opcode !== 3'd0)  begin n_fail++; $display("FAIL reset_opcode: got %h want 0", bus.opcode); end
        n_cmp++; if (bus.ir_addr !== 5'd0) begin n_fail++; $display("FAIL reset_ir_addr: got %h want 00", bus.ir_addr); end
        n_cmp++; if (bus.halted !== 1'b0)  begin n_fail++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
        n_cmp++; if (bus.pc_wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b want 0", bus.pc_wrap); end
        n_cmp++; if (bus.retired !== 16'd0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", bus.retired); end
        @(posedge clk); #1;
        rst_ = 1'b1;
        model_reset();
    endtask

    task automatic test_fetch();
        bus.fetch = 1'b1;
        #1;
        n_cmp++; if (bus.addr !== 5'd0) begin n_fail++; $display("FAIL fetch_addr_pc: got %h want 00", bus.addr); end
        bus.mem_data = 8'hA7; bus.load_ir = 1'b1;
        tick();
        n_cmp++; if (bus.opcode !== 3'b101) begin n_fail++; $display("FAIL fetch_opcode: got %b want 101", bus.opcode); end
        n_cmp++; if (bus.ir_addr !== 5'h07) begin n_fail++; $display("FAIL fetch_ir_addr: got %h want 07", bus.ir_addr); end
        n_cmp++; if (bus.retired !== 16'd1) begin n_fail++; $display("FAIL fetch_retired: got %0d want 1", bus.retired); end
        bus.fetch = 1'b0;
        #1;
        n_cmp++; if (bus.addr !== 5'h07) begin n_fail++; $display("FAIL fetch_addr_operand: got %h want 07", bus.addr); end
        bus.fetch = 1'b1;
    endtask

    task automatic test_wrap();
        bus.mem_data = 8'hFF; bus.load_ir = 1'b1; tick();
        bus.load_pc = 1'b1; tick();
        n_cmp++; if (bus.pc !== 5'h1F) begin n_fail++; $display("FAIL wrap_preload: got %h want 1f", bus.pc); end
        bus.inc_pc = 1'b1; tick();
        n_cmp++; if (bus.pc !== 5'h00) begin n_fail++; $display("FAIL wrap_pc: got %h want 00", bus.pc); end
        n_cmp++; if (bus.pc_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_pulse: got %b want 1", bus.pc_wrap); end
        bus.inc_pc = 1'b1; tick();
        n_cmp++; if (bus.pc !== 5'h01) begin n_fail++; $display("FAIL wrap_next_pc: got %h want 01", bus.pc); end
        n_cmp++; if (bus.pc_wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_one_cycle: got %b want 0", bus.pc_wrap); end
    endtask

    task automatic test_priority();
        bus.mem_data = 8'hE3; bus.load_ir = 1'b1; tick();
        bus.load_pc = 1'b1; bus.inc_pc = 1'b1; tick();
        n_cmp++; if (bus.pc !== 5'h03) begin n_fail++; $display("FAIL prio_loadpc_wins: got %h want 03", bus.pc); end
        n_cmp++; if (bus.pc_wrap !== 1'b0) begin n_fail++; $display("FAIL prio_no_wrap: got %b want 0", bus.pc_wrap); end
        bus.mem_data = 8'hE9; bus.load_ir = 1'b1; bus.load_pc = 1'b1; tick();
        n_cmp++; if (bus.pc !== 5'h03) begin n_fail++; $display("FAIL prio_old_ir_target: got %h want 03", bus.pc); end
        n_cmp++; if (bus.ir_addr !== 5'h09) begin n_fail++; $display("FAIL prio_new_ir: got %h want 09", bus.ir_addr); end
    endtask

    task automatic test_halt();
        int s_pc, s_ir, s_ret;
        // Same-cycle strobe still takes effect while the latch sets.
        bus.halt = 1'b1; bus.inc_pc = 1'b1; tick();
        n_cmp++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_set: got %b want 1", bus.halted); end
        n_cmp++; if (bus.pc !== 5'h04) begin n_fail++; $display("FAIL halt_same_cycle_inc: got %h want 04", bus.pc); end
        s_pc = m_pc; s_ir = m_ir; s_ret = m_ret;
        for (int i = 0; i < 3; i++) begin
            bus.inc_pc = 1'b1; bus.load_pc = 1'b1; bus.load_ir = 1'b1;
            bus.mem_data = 8'($urandom_range(0, 255));
            tick();
        end
        n_cmp++; if (int'(bus.pc) !== s_pc) begin n_fail++; $display("FAIL halt_pc_hold: got %h want %h", bus.pc, s_pc); end
        n_cmp++; if (int'({bus.opcode, bus.ir_addr}) !== s_ir) begin n_fail++; $display("FAIL halt_ir_hold: got %h want %h", {bus.opcode, bus.ir_addr}, s_ir); end
        n_cmp++; if (int'(bus.retired) !== s_ret) begin n_fail++; $display("FAIL halt_ret_hold: got %0d want %0d", bus.retired, s_ret); end
        bus.fetch = 1'b0; #1;
        n_cmp++; if (bus.addr !== bus.ir_addr) begin n_fail++; $display("FAIL halt_addr_mux: got %h want %h", bus.addr, 5'(s_ir % 32)); end
        bus.fetch = 1'b1;
        bus.halt = 1'b1; bus.resume = 1'b1; tick();
        n_cmp++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_beats_resume: got %b want 1", bus.halted); end
        bus.resume = 1'b1; tick();
        n_cmp++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL resume_clears: got %b want 0", bus.halted); end
        bus.inc_pc = 1'b1; tick();
        n_cmp++; if (int'(bus.pc) !== (s_pc + 1) % 32) begin n_fail++; $display("FAIL resume_inc: got %h want %h", bus.pc, 5'((s_pc + 1) % 32)); end
    endtask

`ifdef FETCH_BREAKPOINT_EN
    task automatic test_breakpoint();
        bus.bp_valid = 1'b0; bus.bp_addr = 5'h04;
        bus.mem_data = 8'h04; bus.load_ir = 1'b1; tick();
        bus.load_pc = 1'b1; tick();
        bus.bp_valid = 1'b1;
        bus.mem_data = 8'h55; bus.load_ir = 1'b1; tick();
        n_cmp++; if (bus.bp_hit !== 1'b1) begin n_fail++; $display("FAIL bp_hit: got %b want 1", bus.bp_hit); end
        n_cmp++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL bp_halted: got %b want 1", bus.halted); end
        n_cmp++; if (bus.ir_addr !== 5'h15) begin n_fail++; $display("FAIL bp_ir_loaded: got %h want 15", bus.ir_addr); end
        bus.inc_pc = 1'b1; tick();
        n_cmp++; if (bus.bp_hit !== 1'b0) begin n_fail++; $display("FAIL bp_one_cycle: got %b want 0", bus.bp_hit); end
        n_cmp++; if (bus.pc !== 5'h04) begin n_fail++; $display("FAIL bp_inc_ignored: got %h want 04", bus.pc); end
        bus.bp_valid = 1'b0; bus.resume = 1'b1; tick();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.fetch    = 1'($urandom_range(0, 1));
            bus.mem_data = 8'($urandom_range(0, 255));
            bus.load_ir  = ($urandom_range(0, 2) == 0);
            bus.inc_pc   = ($urandom_range(0, 1) == 0);
            bus.load_pc  = ($urandom_range(0, 5) == 0);
            bus.halt     = ($urandom_range(0, 15) == 0);
            bus.resume   = ($urandom_range(0, 2) == 0);
`ifdef FETCH_BREAKPOINT_EN
            bus.bp_valid = ($urandom_range(0, 3) == 0);
            bus.bp_addr  = 5'($urandom_range(0, 31));
`endif
            #1;
            n_cmp++;
            if (int'(bus.addr) !== (bus.fetch ? m_pc : m_ir % 32)) begin
                n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, bus.addr, 5'(bus.fetch ? m_pc : m_ir % 32));
            end
            tick();
            n_cmp++;
            if (int'(bus.pc) !== m_pc || int'({bus.opcode, bus.ir_addr}) !== m_ir ||
                bus.halted !== m_halted || bus.pc_wrap !== m_wrap || int'(bus.retired) !== m_ret) begin
                n_fail++;
                $display("FAIL rnd_state[%0d]: got pc=%h ir=%h h=%b w=%b r=%0d want pc=%h ir=%h h=%b w=%b r=%0d",
                         i, bus.pc, {bus.opcode, bus.ir_addr}, bus.halted, bus.pc_wrap, bus.retired,
                         5'(m_pc), 8'(m_ir), m_halted, m_wrap, m_ret);
            end
`ifdef FETCH_BREAKPOINT_EN
            n_cmp++; if (bus.bp_hit !== m_bp) begin n_fail++; $display("FAIL rnd_bp[%0d]: got %b want %b", i, bus.bp_hit, m_bp); end
`endif
        end
`ifdef FETCH_BREAKPOINT_EN
        bus.bp_valid = 1'b0;
`endif
    endtask

    task automatic test_async_reset();
        bus.resume = 1'b1; tick();
        bus.mem_data = 8'h6C; bus.load_ir = 1'b1; tick();
        bus.load_pc = 1'b1; tick();
        bus.halt = 1'b1; tick();
        n_cmp++; if (bus.pc !== 5'h0C || bus.halted !== 1'b1) begin n_fail++; $display("FAIL areset_setup: got pc=%h h=%b want pc=0c h=1", bus.pc, bus.halted); end
        @(negedge clk); #2;
        rst_ = 1'b0; bus.inc_pc = 1'b1;
        #1;
        n_cmp++; if (bus.pc !== 5'd0)       begin n_fail++; $display("FAIL areset_pc: got %h want 00", bus.pc); end
        n_cmp++; if (bus.halted !== 1'b0)   begin n_fail++; $display("FAIL areset_halted: got %b want 0", bus.halted); end
        n_cmp++; if (bus.retired !== 16'd0) begin n_fail++; $display("FAIL areset_retired: got %0d want 0", bus.retired); end
        n_cmp++; if ({bus.opcode, bus.ir_addr} !== 8'd0) begin n_fail++; $display("FAIL areset_ir: got %h want 00", {bus.opcode, bus.ir_addr}); end
        @(posedge clk); #1;
        n_cmp++; if (bus.pc !== 5'd0) begin n_fail++; $display("FAIL areset_strobe_discard: got %h want 00", bus.pc); end
        bus.inc_pc = 1'b0; rst_ = 1'b1;
        model_reset();
        bus.inc_pc = 1'b1; tick();
        n_cmp++; if (bus.pc !== 5'd1) begin n_fail++; $display("FAIL areset_release: got %h want 01", bus.pc); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst_ = 1'b0;
        bus.mem_data = '0; bus.fetch = 1'b1; bus.load_ir = 1'b0; bus.inc_pc = 1'b0;
        bus.load_pc = 1'b0; bus.halt = 1'b0; bus.resume = 1'b0;
`ifdef FETCH_BREAKPOINT_EN
        bus.bp_valid = 1'b0; bus.bp_addr = '0;
`endif
        model_reset();
        test_reset();
        test_fetch();
        test_wrap();
        test_priority();
        test_halt();
`ifdef FETCH_BREAKPOINT_EN
        test_breakpoint();
`endif
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
